// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage:
// FSM state encoding, the IF/ID record and the reset/bubble defaults.
package fetch_stage_pkg;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

    // S_REQ : free to issue a request
    // S_WAIT: exactly one request outstanding
    // S_HOLD: response parked in the holding buffer while IF/ID is stalled
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } ifid_t;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register with write enable, flush-to-bubble and
// synchronous active-high reset. A bubble clears valid and forces the
// NOP instruction but leaves pc4 untouched.
module ifid_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_i,      // IF/ID may change this cycle
    input  logic        flush_i,   // force a bubble regardless of we_i
    input  logic        load_i,    // with we_i: capture pc4_i/instr_i as valid
    input  logic [31:0] pc4_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc4_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    ifid_t ifid_q, ifid_d;

    // Next IF/ID contents: flush or an empty write becomes a bubble.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // that no path leaves it unassigned and infers a latch.
        ifid_d = ifid_q;
        if (flush_i || (we_i && !load_i)) begin
            ifid_d.instr = NOP_INSTR;
            ifid_d.valid = 1'b0;
        end else if (we_i) begin
            ifid_d = '{pc4: pc4_i, instr: instr_i, valid: 1'b1};
        end
    end

    // Register update with synchronous reset to an empty slot.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            ifid_q <= '{pc4: 32'h0, instr: NOP_INSTR, valid: 1'b0};
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign pc4_o   = ifid_q.pc4;
    assign instr_o = ifid_q.instr;
    assign valid_o = ifid_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, request/grant/response handshake
// to instruction memory (one request outstanding at most), a one-entry
// holding buffer for responses that arrive while IF/ID is stalled, and
// branch redirect with flush of in-flight fetches.
// Optional feature: define FETCH_PERF_CNT_EN to add perf_bubble_cnt, a
// saturating count of cycles in which IF/ID holds a bubble.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcWrite,
    input  logic        ifid_writeReg,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_bubble_cnt
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  buf_instr_q, buf_instr_d;
    logic         kill_q, kill_d;

    logic         req;
    logic         fire;
    logic [31:0]  target_aligned;
    logic         ifid_we, ifid_flush, ifid_load;
    logic [31:0]  ifid_instr_in;
    logic [31:0]  ifid_pc4_in;

    assign target_aligned = branch_target & 32'hFFFF_FFFC;

    // A new request may go out from S_REQ, or from S_WAIT when the live
    // response is consumed straight into IF/ID this very cycle.
    assign req = !reset && !branch_taken && pcWrite &&
                 ((state_q == S_REQ) ||
                  ((state_q == S_WAIT) && imem_rvalid && !kill_q && ifid_writeReg));
    assign fire = req && imem_gnt;

    assign imem_req  = req;
    assign imem_addr = pc_q;

    // No request is issued between buffering and unloading a response, so
    // fetch_pc_q still names the buffered instruction and its pc4 need not
    // be stored alongside it.
    assign ifid_pc4_in = fetch_pc_q + 32'd4;

    // Next-state, PC/buffer update and IF/ID control.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_pc_d    = fetch_pc_q;
        buf_instr_d   = buf_instr_q;
        kill_d        = kill_q;
        ifid_we       = ifid_writeReg;
        ifid_flush    = 1'b0;
        ifid_load     = 1'b0;
        ifid_instr_in = imem_rdata;

        if (branch_taken) begin
            pc_d       = target_aligned;
            ifid_flush = 1'b1;
            if (state_q == S_WAIT) begin
                if (imem_rvalid) begin
                    // Response for the wrong path lands now: drop it.
                    state_d = S_REQ;
                    kill_d  = 1'b0;
                end else begin
                    // Response still in flight: remember to drop it.
                    kill_d = 1'b1;
                end
            end else begin
                state_d = S_REQ;
            end
        end else begin
            unique case (state_q)
                S_REQ: begin
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = S_REQ;
                        end else if (ifid_writeReg) begin
                            ifid_load = 1'b1;
                            state_d   = S_REQ;
                        end else begin
                            buf_instr_d = imem_rdata;
                            state_d     = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (ifid_writeReg) begin
                        ifid_load     = 1'b1;
                        ifid_instr_in = buf_instr_q;
                        state_d       = S_REQ;
                    end
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase

            if (fire) begin
                fetch_pc_d = pc_q;
                pc_d       = pc_q + 32'd4;
                state_d    = S_WAIT;
            end
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            fetch_pc_q  <= RESET_PC;
            buf_instr_q <= NOP_INSTR;
            kill_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_pc_q  <= fetch_pc_d;
            buf_instr_q <= buf_instr_d;
            kill_q      <= kill_d;
        end
    end

    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk     (clk),
        .reset   (reset),
        .we_i    (ifid_we),
        .flush_i (ifid_flush),
        .load_i  (ifid_load),
        .pc4_i   (ifid_pc4_in),
        .instr_i (ifid_instr_in),
        .pc4_o   (ifid_pc4),
        .instr_o (ifid_instr),
        .valid_o (ifid_valid)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Saturating count of cycles in which IF/ID shows a bubble.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!ifid_valid && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= 32'h0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. A transaction-level reference model
// (PC, outstanding fetch, stale flag, one-entry buffer, IF/ID record) and a
// latency-randomised instruction memory run alongside the DUT; directed
// phases precede a long randomised phase.
module tb_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset         = 1'b1;
    logic        pcWrite       = 1'b0;
    logic        ifid_writeReg = 1'b0;
    logic        branch_taken  = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt      = 1'b0;
    logic        imem_rvalid   = 1'b0;
    logic [31:0] imem_rdata    = 32'h0;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_bubble_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .pcWrite       (pcWrite),
        .ifid_writeReg (ifid_writeReg),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .ifid_pc4      (ifid_pc4),
        .ifid_instr    (ifid_instr),
        .ifid_valid    (ifid_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    // Reference model state
    logic [31:0] m_pc        = 32'h0;
    logic        m_out       = 1'b0;   // a fetch is in flight
    logic [31:0] m_out_addr  = 32'h0;
    logic        m_stale     = 1'b0;   // in-flight fetch belongs to a squashed path
    logic        m_buf_full  = 1'b0;
    logic [31:0] m_buf_instr = 32'h0;
    logic [31:0] m_buf_pc4   = 32'h0;
    logic [31:0] m_ifid_pc4   = 32'h0;
    logic [31:0] m_ifid_instr = 32'h0;
    logic        m_ifid_valid = 1'b0;
    logic [31:0] m_cnt       = 32'h0;

    // Memory model state
    logic        mem_pending = 1'b0;
    logic [31:0] mem_addr    = 32'h0;
    int          mem_wait    = 0;
    int          lat_min     = 1;
    int          lat_max     = 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic pcw, input logic wr,
                        input logic br, input logic [31:0] tgt, input logic gnt);
        logic        rv;
        logic [31:0] rd;
        logic        exp_req;
        logic        delivered;
        logic [31:0] gaddr;

        @(posedge clk);
        #1;
        rv = !rst && mem_pending && (mem_wait == 0);
        rd = rv ? (mem_addr ^ 32'hA5A5_A5A5) : $urandom;
        reset         = rst;
        pcWrite       = pcw;
        ifid_writeReg = wr;
        branch_taken  = br;
        branch_target = tgt;
        imem_gnt      = gnt;
        imem_rvalid   = rv;
        imem_rdata    = rd;

        // The fetch slot is free when nothing is in flight or buffered, or
        // when the in-flight response is handed straight to IF/ID now.
        exp_req = !rst && !br && pcw &&
                  ((!m_out && !m_buf_full) || (m_out && rv && !m_stale && wr));

        #1;
        check("imem_req",   {31'h0, imem_req},   {31'h0, exp_req});
        check("imem_addr",  imem_addr,           m_pc);
        check("ifid_valid", {31'h0, ifid_valid}, {31'h0, m_ifid_valid});
        check("ifid_instr", ifid_instr,          m_ifid_instr);
        check("ifid_pc4",   ifid_pc4,            m_ifid_pc4);
`ifdef FETCH_PERF_CNT_EN
        check("perf_bubble_cnt", perf_bubble_cnt, m_cnt);
`endif

        // Advance model to the state after the coming edge.
        if (rst) begin
            m_pc = 32'h0; m_out = 1'b0; m_stale = 1'b0; m_buf_full = 1'b0;
            m_ifid_pc4 = 32'h0; m_ifid_instr = 32'h0; m_ifid_valid = 1'b0;
            m_cnt = 32'h0;
            mem_pending = 1'b0;
        end else begin
            if (!m_ifid_valid && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 1;
            delivered = 1'b0;
            gaddr     = m_pc;
            if (br) begin
                m_pc = {tgt[31:2], 2'b00};
                m_ifid_instr = 32'h0;
                m_ifid_valid = 1'b0;
                m_buf_full   = 1'b0;
                if (m_out) begin
                    if (rv) begin
                        m_out = 1'b0;
                        m_stale = 1'b0;
                    end else begin
                        m_stale = 1'b1;
                    end
                end
            end else begin
                if (m_out && rv) begin
                    m_out = 1'b0;
                    if (m_stale) begin
                        m_stale = 1'b0;
                    end else if (wr) begin
                        m_ifid_pc4 = m_out_addr + 32'd4;
                        m_ifid_instr = rd;
                        m_ifid_valid = 1'b1;
                        delivered = 1'b1;
                    end else begin
                        m_buf_full  = 1'b1;
                        m_buf_instr = rd;
                        m_buf_pc4   = m_out_addr + 32'd4;
                    end
                end else if (m_buf_full && wr) begin
                    m_ifid_pc4 = m_buf_pc4;
                    m_ifid_instr = m_buf_instr;
                    m_ifid_valid = 1'b1;
                    m_buf_full = 1'b0;
                    delivered = 1'b1;
                end
                if (wr && !delivered) begin
                    m_ifid_instr = 32'h0;
                    m_ifid_valid = 1'b0;
                end
                if (exp_req && gnt) begin
                    m_out = 1'b1;
                    m_out_addr = gaddr;
                    m_pc = gaddr + 32'd4;
                end
            end

            if (rv) mem_pending = 1'b0;
            else if (mem_pending && (mem_wait > 0)) mem_wait--;
            if (exp_req && gnt) begin
                mem_pending = 1'b1;
                mem_addr = gaddr;
                mem_wait = int'($urandom_range(lat_max, lat_min)) - 1;
            end
        end
    endtask

    initial begin
        logic [31:0] tgt;

        // Reset and back-to-back streaming with 1-cycle memory.
        repeat (2) step(1, 1, 1, 0, 32'h0, 1);
        repeat (3) step(0, 1, 1, 0, 32'h0, 1);
        // Stall while the addr-8 response arrives, then release.
        repeat (3) step(0, 0, 0, 0, 32'h0, 1);
        repeat (6) step(0, 1, 1, 0, 32'h0, 1);

        // Redirect while waiting on a slow response.
        lat_min = 3; lat_max = 3;
        step(0, 1, 1, 0, 32'h0, 1);
        step(0, 1, 1, 1, 32'h0000_0103, 1);
        repeat (8) step(0, 1, 1, 0, 32'h0, 1);

        // Redirect coinciding with a response while IF/ID is stalled.
        lat_min = 1; lat_max = 1;
        step(0, 1, 1, 0, 32'h0, 1);
        step(0, 1, 0, 1, 32'h0000_0103, 1);
        repeat (4) step(0, 1, 1, 0, 32'h0, 1);

        // PC wrap from the top word.
        step(0, 1, 1, 1, 32'hFFFF_FFFE, 1);
        repeat (5) step(0, 1, 1, 0, 32'h0, 1);

        // Reset while a slow response is outstanding, then bubbles counted.
        lat_min = 3; lat_max = 3;
        step(0, 1, 1, 0, 32'h0, 1);
        step(1, 1, 1, 0, 32'h0, 1);
        repeat (3) step(0, 0, 0, 0, 32'h0, 1);
        repeat (6) step(0, 1, 1, 0, 32'h0, 1);

        // Randomised traffic.
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            tgt = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
            step((($urandom % 150) == 0),
                 (($urandom % 4) != 0),
                 (($urandom % 4) != 0),
                 (($urandom % 10) == 0),
                 tgt,
                 (($urandom % 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 32-bit pipeline: owns the PC register, issues requests to instruction memory over a request/grant/response handshake, and writes the IF/ID pipeline register. It sits directly upstream of the load-use hazard unit and obeys that unit's `pcWrite` and `ifid_writeReg` stall controls. It also accepts branch redirects from EX, which flush the stage.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded by reset.
- `NOP_INSTR`, 32'h0000_0000, instruction word written into IF/ID for a bubble.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pcWrite`  in  1  from hazard unit; 0 suppresses new fetch requests and PC advance.
- `ifid_writeReg`  in  1  from hazard unit; 0 holds the IF/ID register.
- `branch_taken`  in  1  redirect strobe (one cycle).
- `branch_target`  in  32  redirect address; bits [1:0] ignored (forced 00).
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  word-aligned fetch address (equals `pc`).
- `imem_gnt`  in  1  memory accepts request this cycle.
- `imem_rvalid`  in  1  response valid; earliest one cycle after grant; at most one outstanding.
- `imem_rdata`  in  32  fetched instruction.
- `ifid_pc4`  out  32  fetch address + 4 (mod 2^32) of instruction in IF/ID.
- `ifid_instr`  out  32  instruction in IF/ID.
- `ifid_valid`  out  1  IF/ID holds a real instruction.
- `perf_bubble_cnt`  out  32  bubble counter (only with `FETCH_PERF_CNT_EN`).

## Operation
- FSM states: S_REQ (may request), S_WAIT (one request outstanding), S_HOLD (response buffered, IF/ID stalled).
- Reset: `pc`=RESET_PC, state S_REQ, kill=0, `ifid_valid`=0, `ifid_instr`=NOP_INSTR, `ifid_pc4`=0, counter=0. `imem_req`=0 while reset is high.
- `imem_req` = !reset && !branch_taken && pcWrite && (S_REQ || (S_WAIT && imem_rvalid && !kill && ifid_writeReg)).
- On `imem_req && imem_gnt`:
  - latch `pc` into `fetch_pc`.
  - `pc` <= `pc`+4; 32'hFFFF_FFFC wraps to 0.
  - next state S_WAIT.
- S_WAIT, `imem_rvalid`=1:
  - If kill is set, drop the data and clear kill.
  - Else, if `ifid_writeReg`=1, load IF/ID {`fetch_pc`+4, `imem_rdata`, valid=1}.
  - Else, store in the holding buffer and go to S_HOLD.
  - Next state is S_WAIT if a new grant occurred, otherwise S_REQ (or S_HOLD as above).
- S_HOLD: no request. When `ifid_writeReg`=1, load IF/ID from the buffer and go to S_REQ.
- When `ifid_writeReg`=1 and nothing is delivered: IF/ID gets a bubble (valid=0, NOP_INSTR, pc4 unchanged). When `ifid_writeReg`=0: IF/ID holds.
- `branch_taken`=1 (priority below reset only):
  - `pc` <= {branch_target[31:2],2'b00}.
  - IF/ID <= bubble, even if `ifid_writeReg`=0.
  - S_HOLD: buffer discarded, go to S_REQ.
  - S_WAIT with rvalid this cycle: data dropped, go to S_REQ.
  - S_WAIT without rvalid: set kill, stay in S_WAIT.
  - S_REQ: no request this cycle.
- Reset mid-request: the outstanding response is not tracked. The memory side is reset by the same `reset`.

## Timing
- Back-to-back throughput is one instruction per cycle with 1-cycle memory latency: grant at cycle N, rvalid at N+1, IF/ID valid after edge N+1, next request overlapped at N+1.
- Redirect: new target requested the cycle after `branch_taken`; IF/ID shows a bubble in that cycle.
- Stall: while `pcWrite`=0 and `ifid_writeReg`=0, PC, IF/ID and the buffer are frozen. An in-flight response lands in the buffer.
- All outputs except `imem_req` are registered. `imem_req` is combinational from state and inputs.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `perf_bubble_cnt` exists, resets to 0, increments every cycle `ifid_valid`=0 outside reset, and saturates at 32'hFFFF_FFFF.
- Not defined:
  - port and counter absent; all other behaviour identical.

## Structure
- Shared pipeline package holds the FSM state enum (S_REQ/S_WAIT/S_HOLD), the IF/ID record typedef {pc4, instr, valid}, NOP_INSTR, and RESET_PC defaults.
- One sub-module: `ifid_reg` (IF/ID register with write-enable, flush-to-bubble and synchronous reset). The FSM, PC and buffer remain in `fetch_stage`.

## Test plan
- Reset release, `imem_gnt`=1 always, 1-cycle rvalid, rdata=addr^32'hA5A5_A5A5 -> `imem_addr` 0,4,8,… on consecutive cycles; `ifid_pc4` 4,8,12,… with `ifid_valid`=1 each cycle.
- `pcWrite`=`ifid_writeReg`=0 for 3 cycles while the response for addr 8 arrives -> IF/ID holds the addr-4 instruction; addr-8 word appears the cycle after release; no duplicate or lost fetch.
- `branch_taken` with target 32'h0000_0103 while S_WAIT, rvalid delayed 2 cycles -> stale response dropped; next `imem_addr`=32'h100; IF/ID bubble (NOP_INSTR, valid=0).
- `branch_taken` coinciding with rvalid and `ifid_writeReg`=0 -> IF/ID flushed to bubble; buffer empty; next request 32'h100.
- PC at 32'hFFFF_FFFC granted -> next `imem_addr`=0; `ifid_pc4`=0.
- `reset` asserted in S_WAIT -> next cycle all outputs at reset values; `imem_req`=0; with `FETCH_PERF_CNT_EN`, counter=0 and then increments by 1 per bubble cycle.
